// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder.
//   ModeWrap / ModeSaturate : values for the SATURATE parameter
//   slice_width()           : bits added per pipeline stage (WIDTH / STAGES)
package pipelined_adder_pkg;

  localparam int unsigned ModeWrap     = 0;
  localparam int unsigned ModeSaturate = 1;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bundle for the pipelined adder.
//   in_valid/in_ready   : operand handshake (a, b, sub)
//   out_valid/out_ready : result handshake (sum, overflow, carry_out)
//   master : producer/consumer side, slave : adder side
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, overflow, carry_out
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, overflow, carry_out
  );
endinterface

// File: rtl/adder_slice.sv
// Combinational Width-bit adder with carry in/out; one instance per pipeline stage.
//   a_i, b_i : slice operands
//   carry_i  : carry from the previous slice
//   sum_o    : slice sum
//   carry_o  : carry out of the slice MSB
module adder_slice #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             carry_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{Width{1'b0}}, carry_i};
endmodule

// File: rtl/pipelined_adder.sv
// Signed add/subtract split into STAGES carry-chained slices, one slice per cycle.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; flushes every in-flight result
//   bus   : valid/ready operand input and result output (slave modport)
// Latency is STAGES cycles; the whole pipe stalls together when the result is
// held (out_valid && !out_ready), so in_ready is simply the global advance.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned STAGES   = 4,
  parameter int unsigned SATURATE = ModeWrap
) (
  input  logic             clk,
  input  logic             reset,
  pipelined_adder_if.slave bus
);

  localparam int unsigned SliceW = slice_width(WIDTH, STAGES);
  localparam int unsigned Last   = STAGES - 1;
  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH % STAGES != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be an integer multiple of STAGES");
  end

  // Stage k inputs (*_st) and registered stage k outputs (*_q).
  // b is carried in its effective (already inverted for subtract) form.
  logic [WIDTH-1:0]  a_st [STAGES];
  logic [WIDTH-1:0]  b_st [STAGES];
  logic [WIDTH-1:0]  s_st [STAGES];
  logic [STAGES-1:0] c_st;
  logic [STAGES-1:0] v_st;

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0]  s_d [STAGES];
  logic [SliceW-1:0] slice_sum [STAGES];
  logic [STAGES-1:0] slice_carry;

  logic advance;
  logic a_sign, b_sign, r_sign, ovf;

  assign advance = !v_q[Last] || bus.out_ready;

  always_comb begin
    a_st[0] = bus.a;
    b_st[0] = bus.sub ? ~bus.b : bus.b;
    s_st[0] = '0;
    c_st[0] = bus.sub;
    v_st[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_st[k] = a_q[k-1];
      b_st[k] = b_q[k-1];
      s_st[k] = s_q[k-1];
      c_st[k] = c_q[k-1];
      v_st[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(
      .Width(SliceW)
    ) u_slice (
      .a_i    (a_st[k][k*SliceW +: SliceW]),
      .b_i    (b_st[k][k*SliceW +: SliceW]),
      .carry_i(c_st[k]),
      .sum_o  (slice_sum[k]),
      .carry_o(slice_carry[k])
    );
  end

  // Lower slices already finished ride along; this stage fills in its own slice.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = s_st[k];
      s_d[k][k*SliceW +: SliceW] = slice_sum[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_st[k];
        b_q[k] <= b_st[k];
        s_q[k] <= s_d[k];
      end
      c_q <= slice_carry;
      v_q <= v_st;
    end
  end

  // Signed overflow: operands agree in sign but the raw result does not.
  always_comb begin
    a_sign = a_q[Last][WIDTH-1];
    b_sign = b_q[Last][WIDTH-1];
    r_sign = s_q[Last][WIDTH-1];
    ovf    = (a_sign == b_sign) && (r_sign != a_sign);

    bus.sum = s_q[Last];
    if (SATURATE == ModeSaturate && ovf) begin
      bus.sum = a_sign ? SatMin : SatMax;
    end
    bus.overflow  = ovf;
    bus.carry_out = c_q[Last];
    bus.out_valid = v_q[Last];
    bus.in_ready  = advance;
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: a wrapping and a saturating instance see
// identical stimulus; a monitor logs every consumed result with its edge index.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic [31:0] sum_w;
    logic        ovf_w;
    logic        cy_w;
    logic [31:0] sum_s;
    logic        ovf_s;
    logic        cy_s;
    int          stamp;
  } res_t;

  res_t res_q[$];
  int   acc_q[$];

  pipelined_adder_if #(.WIDTH(32)) bus_w ();
  pipelined_adder_if #(.WIDTH(32)) bus_s ();

  assign bus_s.in_valid  = bus_w.in_valid;
  assign bus_s.a         = bus_w.a;
  assign bus_s.b         = bus_w.b;
  assign bus_s.sub       = bus_w.sub;
  assign bus_s.out_ready = bus_w.out_ready;

  pipelined_adder #(
    .WIDTH(32), .STAGES(4), .SATURATE(ModeWrap)
  ) u_dut_wrap (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_w)
  );

  pipelined_adder #(
    .WIDTH(32), .STAGES(4), .SATURATE(ModeSaturate)
  ) u_dut_sat (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset && bus_w.out_valid && bus_w.out_ready) begin
      res_q.push_back('{sum_w: bus_w.sum, ovf_w: bus_w.overflow, cy_w: bus_w.carry_out,
                        sum_s: bus_s.sum, ovf_s: bus_s.overflow, cy_s: bus_s.carry_out,
                        stamp: cyc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "tb_pipelined_adder watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and hold it until it is accepted; in_valid stays high.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int n = 0;
    bus_w.in_valid = 1'b1;
    bus_w.a = a;
    bus_w.b = b;
    bus_w.sub = sub;
    #1;
    while (!bus_w.in_ready && n < 64) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!bus_w.in_ready) begin
      check("drive_in_ready_timeout", 32'(bus_w.in_ready), 32'(1'b1));
      bus_w.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_q.push_back(cyc);
    #1;
  endtask

  task automatic idle();
    bus_w.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] sum, input logic ovf,
                               input logic cy, input logic [31:0] sat_sum, input bit chk_lat);
    res_t r;
    int   acc = -1;
    int   n = 0;
    while (res_q.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    if (res_q.size() == 0) begin
      check({tag, "_timeout"}, 32'(res_q.size()), 32'd1);
      return;
    end
    r = res_q.pop_front();
    if (acc_q.size() > 0) acc = acc_q.pop_front();
    check({tag, "_sum"}, r.sum_w, sum);
    check({tag, "_ovf"}, 32'(r.ovf_w), 32'(ovf));
    check({tag, "_carry"}, 32'(r.cy_w), 32'(cy));
    check({tag, "_sat_sum"}, r.sum_s, sat_sum);
    check({tag, "_sat_ovf"}, 32'(r.ovf_s), 32'(ovf));
    check({tag, "_sat_carry"}, 32'(r.cy_s), 32'(cy));
    if (chk_lat) check({tag, "_latency"}, 32'(r.stamp - acc), 32'd4);
  endtask

  initial begin
    reset = 1'b0;
    bus_w.in_valid = 1'b0;
    bus_w.a = '0;
    bus_w.b = '0;
    bus_w.sub = 1'b0;
    bus_w.out_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", 32'(bus_w.out_valid), 32'd0);
    check("rst_sum", bus_w.sum, 32'd0);
    check("rst_ovf", 32'(bus_w.overflow), 32'd0);
    check("rst_carry", 32'(bus_w.carry_out), 32'd0);
    check("rst_sat_sum", bus_s.sum, 32'd0);
    check("rst_in_ready", 32'(bus_w.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Single add with explicit latency probing.
    drive(32'd1, 32'd2, 1'b0);
    idle();
    tick();
    tick();
    check("lat_early_valid", 32'(bus_w.out_valid), 32'd0);
    tick();
    check("lat_on_time_valid", 32'(bus_w.out_valid), 32'd1);
    check("lat_on_time_sum", bus_w.sum, 32'd3);
    expect_result("add_1_2", 32'd3, 1'b0, 1'b0, 32'd3, 1'b1);

    // Back-to-back stream including ripple across slice boundaries.
    drive(32'd0, 32'hFFFF_FFFF, 1'b0);
    drive(32'(-100000), 32'd100000, 1'b0);
    drive(32'd5, 32'd7, 1'b1);
    drive(32'h7FFF_FFFF, 32'd2, 1'b0);
    drive(32'h8000_0000, 32'd1, 1'b1);
    drive(32'h7FFF_FFFF, 32'h8000_0001, 1'b0);
    drive(32'h00FF_FFFF, 32'd1, 1'b0);
    drive(32'h0100_0000, 32'd1, 1'b1);
    idle();
    expect_result("s_0_m1", 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    expect_result("s_cancel", 32'd0, 1'b0, 1'b1, 32'd0, 1'b1);
    expect_result("s_5_sub_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1);
    expect_result("pos_ovf", 32'h8000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
    expect_result("neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
    expect_result("max_plus_negmax", 32'd0, 1'b0, 1'b1, 32'd0, 1'b1);
    expect_result("ripple_add", 32'h0100_0000, 1'b0, 1'b0, 32'h0100_0000, 1'b1);
    expect_result("ripple_sub", 32'h00FF_FFFF, 1'b0, 1'b1, 32'h00FF_FFFF, 1'b1);

    // Backpressure: 6 stalled cycles with 5 operand sets offered.
    repeat (6) tick();
    fork
      begin
        drive(32'd10, 32'd1, 1'b0);
        drive(32'd20, 32'd2, 1'b0);
        drive(32'd30, 32'd3, 1'b1);
        drive(32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0);
        drive(32'd100, 32'd100, 1'b1);
        idle();
      end
      begin
        bus_w.out_ready = 1'b0;
        repeat (5) tick();
        check("bp_in_ready_full", 32'(bus_w.in_ready), 32'd0);
        check("bp_valid_held", 32'(bus_w.out_valid), 32'd1);
        check("bp_sum_held_a", bus_w.sum, 32'd11);
        tick();
        check("bp_in_ready_still", 32'(bus_w.in_ready), 32'd0);
        check("bp_sum_held_b", bus_w.sum, 32'd11);
        bus_w.out_ready = 1'b1;
      end
    join
    expect_result("bp_0", 32'd11, 1'b0, 1'b0, 32'd11, 1'b0);
    expect_result("bp_1", 32'd22, 1'b0, 1'b0, 32'd22, 1'b0);
    expect_result("bp_2", 32'd27, 1'b0, 1'b1, 32'd27, 1'b0);
    expect_result("bp_3", 32'hFFFF_FFF5, 1'b0, 1'b1, 32'hFFFF_FFF5, 1'b0);
    expect_result("bp_4", 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);

    // Reset in flight: first result escapes before reset, the rest are flushed.
    repeat (4) tick();
    drive(32'd1, 32'd1, 1'b0);
    drive(32'd2, 32'd2, 1'b0);
    drive(32'd3, 32'd3, 1'b0);
    idle();
    tick();
    tick();
    check("rst_pre_valid", 32'(bus_w.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bus_w.out_valid), 32'd0);
    check("rst_mid_sum", bus_w.sum, 32'd0);
    check("rst_mid_carry", 32'(bus_w.carry_out), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) tick();
    check("rst_no_stale", 32'(res_q.size()), 32'd1);
    check("rst_idle_valid", 32'(bus_w.out_valid), 32'd0);
    check("rst_idle_in_ready", 32'(bus_w.in_ready), 32'd1);
    expect_result("rst_escaped", 32'd2, 1'b0, 1'b0, 32'd2, 1'b1);
    acc_q.delete();
    drive(32'd10, 32'd20, 1'b0);
    idle();
    expect_result("rst_after", 32'd30, 1'b0, 1'b0, 32'd30, 1'b1);

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES (elaboration error otherwise).
REQ-003 Parameter SATURATE, default 0: 0 = two's-complement wrap, 1 = signed saturation on overflow.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand set present on a/b/sub.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  signed operand A.
REQ-009 b  input  WIDTH  signed operand B.
REQ-010 sub  input  1  0 = A+B, 1 = A-B.
REQ-011 out_valid  output  1  result present on sum/overflow/carry_out.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  signed result.
REQ-014 overflow  output  1  signed overflow occurred for this result.
REQ-015 carry_out  output  1  unsigned carry (add) / no-borrow (sub) from MSB.

Function
REQ-016 Transfer in: a/b/sub captured on a rising edge where in_valid && in_ready.
REQ-017 Transfer out: result consumed on a rising edge where out_valid && out_ready.
REQ-018 Global advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependency on in_valid).
REQ-019 When advance = 0 every stage register, including valid bits, SHALL hold; sum/overflow/carry_out SHALL stay stable while out_valid && !out_ready.
REQ-020 Each stage k (0..STAGES-1) adds slice [k*W/S +: W/S] with carry from stage k-1; unprocessed upper slices skew forward, completed lower slices carry forward.
REQ-021 Subtract: operand B bitwise inverted, stage-0 carry-in = 1; add: carry-in = 0.
REQ-022 Latency exactly STAGES cycles from input transfer to out_valid with out_ready held high; throughput one result per cycle.
REQ-023 Bubbles (in_valid = 0 during advance) SHALL propagate as invalid slots; results SHALL emerge in input order, none dropped or duplicated.
REQ-024 overflow = (A sign == effective-B sign) && (raw-sum sign != A sign), evaluated at final stage.
REQ-025 SATURATE = 0: sum = raw WIDTH-bit result modulo 2^WIDTH.
REQ-026 SATURATE = 1 and overflow: sum = 2^(WIDTH-1)-1 if A non-negative, else -2^(WIDTH-1); overflow still reported as 1.
REQ-027 carry_out SHALL reflect the raw carry regardless of SATURATE.
REQ-028 Simultaneous output consume and input accept in the same cycle SHALL both occur (full-rate streaming).

Reset
REQ-029 Reset asserted SHALL immediately clear all stage valid bits; out_valid = 0, sum = 0, overflow = 0, carry_out = 0.
REQ-030 in_ready SHALL be 1 whenever reset is not asserted and out_valid = 0.
REQ-031 Reset mid-operation SHALL discard all in-flight results; first input after deassertion SHALL produce a correct result after STAGES cycles.

Structure
REQ-032 Shared package holds the mode constants (wrap/saturate) and the slice-width function WIDTH/STAGES.
REQ-033 One sub-module, adder_slice: combinational W/S-bit add with carry-in/carry-out, instantiated STAGES times; pipeline registers and handshake live in pipelined_adder.

Verification (WIDTH=32, STAGES=4, out_ready=1 unless stated)
REQ-034 a=1, b=2, sub=0 -> sum=3, overflow=0, out_valid exactly 4 cycles after accept.
REQ-035 Stream back-to-back: (0,-1), (-100000,100000), (5,7,sub=1) -> sum=-1, 0, -2 in order on consecutive cycles; carry_out=1 for the second.
REQ-036 a=2147483647, b=2: SATURATE=0 -> sum=-2147483647, overflow=1; SATURATE=1 -> sum=2147483647, overflow=1.
REQ-037 a=-2147483648, b=1, sub=1 -> overflow=1; SATURATE=1 -> sum=-2147483648; a=2147483647, b=-2147483647 -> sum=0, overflow=0.
REQ-038 Hold out_ready=0 for 6 cycles with 5 inputs offered -> in_ready drops once pipeline full, held result stable, all 5 results delivered in order after release.
REQ-039 Assert reset 2 cycles after 3 accepts -> out_valid=0 immediately, no stale results after deassertion; next input a=10, b=20 -> sum=30 after 4 cycles.
